// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// mdu_iter : iterative shift-add / restoring-divide MUL/DIV/REM unit, 1 bit/cycle
// req fields flattened: op 2'b00 MUL, 2'b01 DIV, 2'b10 REM, 2'b11 MUL.  Rev 1.0
// ============================================================================
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            req_dw,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_ia,
    input  logic [XLEN-1:0] req_ia_orig,
    input  logic [XLEN-1:0] req_ib,
    input  logic            req_signed,
    output logic            req_ready,
    input  logic            flush,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    input  logic            resp_ready
);

    localparam logic [1:0] c_op_div = 2'b01;
    localparam logic [1:0] c_op_rem = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [5:0]      r_cnt;
    logic [1:0]      r_op;
    logic            r_dw;
    logic            r_neg;
    logic [XLEN-1:0] r_x;   // MUL accumulator / DIV partial remainder
    logic [XLEN-1:0] r_y;   // MUL shifted multiplicand / DIV divisor
    logic [XLEN-1:0] r_z;   // MUL shifted multiplier / DIV quotient

    logic [XLEN-1:0] w_a, w_b, w_amag, w_bmag, w_min, w_orig, w_special_data;
    logic            w_sa, w_sb, w_is_div, w_is_rem, w_b_zero, w_ovf, w_special;
    logic            w_accept, w_neg;
    logic [XLEN:0]   w_shift, w_diff;
    logic [XLEN-1:0] w_sel, w_res;

    // Operand preparation for the request presented this cycle
    assign w_a      = req_dw ? req_ia : {{32{req_signed & req_ia[31]}}, req_ia[31:0]};
    assign w_b      = req_dw ? req_ib : {{32{req_signed & req_ib[31]}}, req_ib[31:0]};
    assign w_sa     = req_signed & w_a[XLEN-1];
    assign w_sb     = req_signed & w_b[XLEN-1];
    assign w_amag   = w_sa ? -w_a : w_a;
    assign w_bmag   = w_sb ? -w_b : w_b;
    assign w_is_div = (req_op == c_op_div);
    assign w_is_rem = (req_op == c_op_rem);
    assign w_neg    = w_is_rem ? w_sa : (w_sa ^ w_sb);
    assign w_min    = req_dw ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
    assign w_orig   = req_dw ? req_ia_orig : {{32{req_ia_orig[31]}}, req_ia_orig[31:0]};
    assign w_b_zero = (w_b == '0);
    assign w_ovf    = req_signed && (w_a == w_min) && (w_b == '1);
    assign w_special = (w_is_div || w_is_rem) && (w_b_zero || w_ovf);
    assign w_accept = req_valid && (r_state == S_IDLE) && !flush;

    always_comb begin
        w_special_data = '0;
        if (w_b_zero)
            w_special_data = w_is_div ? '1 : w_orig;
        else if (w_is_div)
            w_special_data = w_a;
    end

    // 65-bit trial subtraction so unsigned divisors with bit 63 set still work
    assign w_shift = {r_x, r_z[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_y};

    assign w_sel = (r_op == c_op_div) ? r_z : r_x;
    assign w_res = r_neg ? -w_sel : w_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept)
                    w_next = w_special ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                if (flush)
                    w_next = S_IDLE;
                else if (r_cnt == 6'd0)
                    w_next = S_FIX;
            end
            S_FIX: begin
                w_next = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                if (flush || resp_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_dw      <= 1'b0;
            r_neg     <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            resp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= req_op;
                        r_dw  <= req_dw;
                        r_neg <= w_neg;
                        r_cnt <= req_dw ? 6'd63 : 6'd31;
                        r_x   <= '0;
                        r_y   <= w_bmag;
                        // word divides pre-shift so the 32 iterations see bits [31:0]
                        if ((w_is_div || w_is_rem) && !req_dw)
                            r_z <= {w_amag[31:0], 32'b0};
                        else
                            r_z <= w_amag;
                        if (w_special)
                            resp_data <= w_special_data;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 6'd1;
                    if ((r_op == c_op_div) || (r_op == c_op_rem)) begin
                        if (!w_diff[XLEN]) begin
                            r_x <= w_diff[XLEN-1:0];
                            r_z <= {r_z[XLEN-2:0], 1'b1};
                        end else begin
                            r_x <= w_shift[XLEN-1:0];
                            r_z <= {r_z[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_x <= r_x + (r_z[0] ? r_y : '0);
                        r_y <= {r_y[XLEN-2:0], 1'b0};
                        r_z <= {1'b0, r_z[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    resp_data <= r_dw ? w_res : {{32{w_res[31]}}, w_res[31:0]};
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// tb_mdu_iter : directed + randomized self-checking bench for mdu_iter
// Rev 1.0
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid = 1'b0;
    logic        req_dw = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [63:0] req_ia = '0;
    logic [63:0] req_ia_orig = '0;
    logic [63:0] req_ib = '0;
    logic        req_signed = 1'b0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.XLEN(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_dw     (req_dw),
        .req_op     (req_op),
        .req_ia     (req_ia),
        .req_ia_orig(req_ia_orig),
        .req_ib     (req_ib),
        .req_signed (req_signed),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [63:0] prep(input logic dw, input logic sgn, input logic [63:0] v);
        if (dw) return v;
        return sgn ? sext32(v) : {32'b0, v[31:0]};
    endfunction

    function automatic logic is_special(input logic dw, input logic [1:0] op,
                                        input logic [63:0] ia, input logic [63:0] ib, input logic sgn);
        logic [63:0] a, b, mn;
        a  = prep(dw, sgn, ia);
        b  = prep(dw, sgn, ib);
        mn = dw ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
        return (op == 2'b01 || op == 2'b10) && (b == 0 || (sgn && a == mn && b == '1));
    endfunction

    // Reference result from plain arithmetic on the prepared operands
    function automatic logic [63:0] ref_model(input logic dw, input logic [1:0] op,
                                              input logic [63:0] ia, input logic [63:0] orig,
                                              input logic [63:0] ib, input logic sgn);
        logic [63:0] a, b, mn, r;
        logic signed [63:0] sa, sb;
        logic ovf;
        a   = prep(dw, sgn, ia);
        b   = prep(dw, sgn, ib);
        mn  = dw ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_8000_0000;
        ovf = sgn && a == mn && b == '1;
        sa  = a;
        sb  = b;
        r   = '0;
        if (op == 2'b01) begin
            if (b == 0) r = '1;
            else if (ovf) r = a;
            else if (sgn) r = sa / sb;
            else r = a / b;
        end else if (op == 2'b10) begin
            if (b == 0) r = orig;
            else if (ovf) r = '0;
            else if (sgn) r = sa % sb;
            else r = a % b;
        end else begin
            r = a * b;
        end
        return dw ? r : sext32(r);
    endfunction

    task automatic drive_req(input logic dw, input logic [1:0] op, input logic [63:0] ia,
                             input logic [63:0] orig, input logic [63:0] ib, input logic sgn);
        @(negedge clk);
        req_valid   = 1'b1;
        req_dw      = dw;
        req_op      = op;
        req_ia      = ia;
        req_ia_orig = orig;
        req_ib      = ib;
        req_signed  = sgn;
    endtask

    task automatic run_op(input string tag, input logic dw, input logic [1:0] op,
                          input logic [63:0] ia, input logic [63:0] orig,
                          input logic [63:0] ib, input logic sgn, input int hold);
        logic [63:0] exp;
        int exp_lat, lat;
        exp     = ref_model(dw, op, ia, orig, ib, sgn);
        exp_lat = is_special(dw, op, ia, ib, sgn) ? 1 : (dw ? 66 : 34);
        resp_ready = 1'b0;
        drive_req(dw, op, ia, orig, ib, sgn);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        if (exp_lat > 1) check({tag, " busy_ready"}, {63'b0, req_ready}, 64'd0);
        while (!resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " data"}, resp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold_valid"}, {63'b0, resp_valid}, 64'd1);
            check({tag, " hold_data"}, resp_data, exp);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " post_valid"}, {63'b0, resp_valid}, 64'd0);
        check({tag, " post_ready"}, {63'b0, req_ready}, 64'd1);
    endtask

    initial begin
        logic        dw, sgn;
        logic [1:0]  op;
        logic [63:0] ia, ib;
        int          k;

        reset = 1'b1;
        #1;
        check("reset req_ready", {63'b0, req_ready}, 64'd1);
        check("reset resp_valid", {63'b0, resp_valid}, 64'd0);
        check("reset resp_data", resp_data, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("mul_neg1x3", 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 0);
        run_op("divw_m7_2", 1'b0, 2'b01, 64'h0000_0000_FFFF_FFF9, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 0);
        run_op("remw_m7_2", 1'b0, 2'b10, 64'h0000_0000_FFFF_FFF9, 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 0);
        run_op("div_by0", 1'b1, 2'b01, 64'd42, 64'd42, 64'd0, 1'b1, 0);
        run_op("rem_by0", 1'b1, 2'b10, 64'd42, 64'd42, 64'd0, 1'b1, 0);
        run_op("div_ovf", 1'b1, 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, '1, 1'b1, 0);
        run_op("rem_ovf", 1'b1, 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, '1, 1'b1, 0);
        run_op("divuw_ff_1", 1'b0, 2'b01, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0);
        run_op("divw_ovf", 1'b0, 2'b01, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 0);
        run_op("divu_big", 1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hC000_0000_0000_0000, 1'b0, 0);
        run_op("op11_mul", 1'b1, 2'b11, 64'd9, 64'd9, 64'd11, 1'b0, 0);

        // Flush mid-BUSY discards the result; the next request completes normally
        drive_req(1'b1, 2'b00, 64'd123, 64'd123, 64'd456, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy valid", {63'b0, resp_valid}, 64'd0);
        check("flush_busy ready", {63'b0, req_ready}, 64'd1);
        run_op("mul_6x7", 1'b1, 2'b00, 64'd6, 64'd6, 64'd7, 1'b1, 5);

        // Flush with a request in IDLE: the request must be ignored
        drive_req(1'b1, 2'b01, 64'd5, 64'd5, 64'd0, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        check("flush_idle valid", {63'b0, resp_valid}, 64'd0);

        // Flush beats a held DONE
        drive_req(1'b1, 2'b01, 64'd5, 64'd5, 64'd0, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("flush_done pre", {63'b0, resp_valid}, 64'd1);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done valid", {63'b0, resp_valid}, 64'd0);

        // Asynchronous reset in the middle of BUSY
        drive_req(1'b1, 2'b00, 64'd77, 64'd77, 64'd3, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst ready", {63'b0, req_ready}, 64'd1);
        check("async_rst valid", {63'b0, resp_valid}, 64'd0);
        check("async_rst data", resp_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 40; n++) begin
            dw  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            ia  = {$urandom, $urandom};
            ib  = {$urandom, $urandom};
            k   = $urandom_range(0, 7);
            if (k == 0) begin
                ia = 64'($urandom_range(0, 100)) - 64'd50;
                ib = 64'($urandom_range(0, 20)) - 64'd10;
            end else if (k == 1) begin
                ib = '0;
            end else if (k == 2) begin
                ia = dw ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
                ib = '1;
            end else if (k == 3) begin
                ib = ib >> $urandom_range(20, 60);
            end
            run_op($sformatf("rand%0d", n), dw, op, ia, (k == 4) ? {$urandom, $urandom} : ia, ib, sgn,
                   (k == 5) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the EX stage.
- Consumes one `mbus_req_t` from EX when an instruction has `rvm` set. Returns a 64-bit result that EX forwards into `REG_EX_MEM.aluOut`.
- EX stalls while the unit is busy.
- Uses one shift-add / restoring-divide datapath, one bit per cycle, for MUL, DIV and REM in both 32-bit (`dw=0`) and 64-bit (`dw=1`) forms.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  EX presents a request
- req  input  `mbus_req_t`  dw, op, ia, ia_orig, ib
- req_signed  input  1  1 = signed operation (DIV/REM/MUL), 0 = unsigned (DIVU/REMU)
- req_ready  output  1  unit can accept a request this cycle
- flush  input  1  discard in-flight operation (pipeline redirect/trap)
- resp_valid  output  1  result valid
- resp_data  output  64  result
- resp_ready  input  1  EX consumes the result

Behaviour:
- States: IDLE, BUSY, FIX, DONE.
- Reset (async, any state): state=IDLE; req_ready=1; resp_valid=0; resp_data=0; all internal registers=0.
- Handshake:
  - Accept occurs when req_valid && req_ready; req_ready=1 only in IDLE.
  - resp_valid=1 only in DONE. resp_data is held stable until resp_valid && resp_ready, then state goes to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Operand prep (accept cycle, registered):
  - dw=1: A=ia, B=ib, N=64.
  - dw=0: A=ia[31:0], B=ib[31:0], each sign-extended if req_signed else zero-extended to 64; N=32.
  - Signed MUL/DIV/REM: iterate on magnitudes |A|, |B|; record the result sign (DIV: sA^sB; REM: sA).
- Special cases, detected at accept; the state goes IDLE->DONE directly, so resp_valid is high the next cycle:
  - DIV, B=0: result all ones (0xFFFF_FFFF_FFFF_FFFF).
  - REM, B=0: result = ia_orig (dw=0: sign-extend ia_orig[31:0]).
  - Signed DIV, A=most-negative (dw=1: 0x8000_0000_0000_0000; dw=0: 0xFFFF_FFFF_8000_0000) and B=-1: result = A.
  - Signed REM, same operands: result 0.
- BUSY:
  - 6-bit counter cnt starts at N-1 and decrements once per cycle; BUSY->FIX when cnt==0, giving exactly N BUSY cycles.
  - MUL: acc += (mplier[0] ? mcand : 0); mcand <<= 1; mplier >>= 1. Only the low 64 bits are kept (no MULH).
  - DIV/REM (restoring): rem = {rem[62:0], quo[63]}; quo <<= 1; if rem >= divisor then rem -= divisor and quo[0]=1. In word mode the quotient register is pre-shifted so that the N iterations consume bits [31:0].
- FIX (one cycle):
  - Apply the sign: negate if the recorded sign=1.
  - Select by op: acc for MUL, quo for DIV, rem for REM.
  - dw=0: result = sign-extend(result[31:0]).
  - Register into resp_data; FIX->DONE.
- Latency (accept edge to resp_valid high):
  - normal: N+2 cycles, i.e. 66 for dw=1, 34 for dw=0;
  - special cases: 1 cycle.
- Flush:
  - In BUSY/FIX/DONE: next edge -> IDLE, resp_valid=0, result discarded.
  - Flush together with req_valid in IDLE: the request is not accepted.
  - Flush takes priority over resp_ready.
- op=REM encoding 2'b10. Any other op value (2'b11) is treated as MUL.
- Backpressure: DONE persists indefinitely while resp_ready=0; no internal state changes.

Test Plan:
- dw=1, MUL, ia=0xFFFF_FFFF_FFFF_FFFF (-1), ib=3, signed -> after 66 cycles resp_data=0xFFFF_FFFF_FFFF_FFFD.
- dw=0, DIV, signed, ia=0x0000_0000_FFFF_FFF9 (-7 in low word), ib=2 -> after 34 cycles resp_data=0xFFFF_FFFF_FFFF_FFFD (-3). Same operands with REM -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero: dw=1 DIV, ia=42, ib=0 -> resp_valid 1 cycle later, data=0xFFFF_FFFF_FFFF_FFFF. REM, ia_orig=42 -> data=42.
- Signed overflow: dw=1 DIV, ia=0x8000_0000_0000_0000, ib=-1 -> data=0x8000_0000_0000_0000 in 1 cycle. REM -> 0.
- Unsigned dw=0 DIVU, ia=0xFFFF_FFFF, ib=1, req_signed=0 -> data=0xFFFF_FFFF_FFFF_FFFF (sign-extended word).
- Flush at BUSY cycle 10, then new request MUL 6*7 -> no response for the first request; second returns 42 after 66 cycles. Holding resp_ready=0 for 5 cycles keeps resp_valid=1 and data=42 stable. Asserting reset mid-BUSY makes req_ready=1 and resp_valid=0 immediately.
